dm_bridge: RTL and testbench

DM_BRIDGE -- requirements
Module: dm_bridge

---
 rtl/dm_bridge.sv | 180 ++++++++++++++++++
 tb/tb_dm_bridge.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_bridge.sv
// Data-memory bridge between the CPU load/store unit and a ready/valid word bus.
// Three-state FSM (IDLE -> ACCESS -> DONE). It latches the request when it leaves
// IDLE, drives lane-replicated write data with byte enables, and extends load data
// back to the register file. Misaligned or illegal requests never reach the bus.
// An access aborts with an error once its wait counter hits TIMEOUT.

module dm_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        mem_w,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [2:0]  dm_ctrl,
    output logic [31:0] rdata_out,
    output logic        cpu_stall,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    // Counter must be able to hold TIMEOUT itself.
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    // Access type encodings on dm_ctrl.
    localparam logic [2:0] CtrlWord  = 3'b000;
    localparam logic [2:0] CtrlHalf  = 3'b001;
    localparam logic [2:0] CtrlHalfU = 3'b010;
    localparam logic [2:0] CtrlByte  = 3'b011;
    localparam logic [2:0] CtrlByteU = 3'b100;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   wait_cnt_q;
    logic [2:0]        ctrl_q;
    logic [1:0]        lane_q;

    logic              acc_misaligned;
    logic              acc_illegal;
    logic              acc_error;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_data;

    // Decode the incoming request: legality, alignment, byte enables, write data.
    always_comb begin
        acc_misaligned = 1'b0;
        acc_illegal    = 1'b0;
        req_be         = 4'b0000;
        req_wdata      = wdata_in;
        case (dm_ctrl)
            CtrlWord: begin
                acc_misaligned = (addr_in[1:0] != 2'b00);
                req_be         = 4'b1111;
                req_wdata      = wdata_in;
            end
            CtrlHalf, CtrlHalfU: begin
                acc_misaligned = addr_in[0];
                // Unsigned variants have no store meaning.
                acc_illegal    = mem_w && (dm_ctrl == CtrlHalfU);
                req_be         = addr_in[1] ? 4'b1100 : 4'b0011;
                req_wdata      = {2{wdata_in[15:0]}};
            end
            CtrlByte, CtrlByteU: begin
                acc_illegal    = mem_w && (dm_ctrl == CtrlByteU);
                req_be         = 4'b0001 << addr_in[1:0];
                req_wdata      = {4{wdata_in[7:0]}};
            end
            default: begin
                acc_illegal    = 1'b1;
            end
        endcase
        acc_error = acc_misaligned | acc_illegal;
    end

    // Select the addressed lane of the bus word and extend it per latched access type.
    always_comb begin
        byte_sel  = bus_rdata[7:0];
        half_sel  = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_data = bus_rdata;
        case (lane_q)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        case (ctrl_q)
            CtrlHalf:  load_data = {{16{half_sel[15]}}, half_sel};
            CtrlHalfU: load_data = {16'h0000, half_sel};
            CtrlByte:  load_data = {{24{byte_sel[7]}}, byte_sel};
            CtrlByteU: load_data = {24'h000000, byte_sel};
            default:   load_data = bus_rdata;
        endcase
    end

    // Stall the CPU while a request is being accepted or is on the bus; never in reset.
    assign cpu_stall = reset & (((state_q == StIdle) & cpu_req) | (state_q == StAccess));

    // Bridge FSM with registered bus outputs, error pulse and load write-back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            ctrl_q     <= 3'b000;
            lane_q     <= 2'b00;
            rdata_out  <= 32'h0000_0000;
            bus_err    <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0000_0000;
            bus_wdata  <= 32'h0000_0000;
            bus_be     <= 4'b0000;
        end else begin
            // The error flag is a single-cycle pulse covering only the DONE cycle.
            bus_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cpu_req) begin
                        ctrl_q <= dm_ctrl;
                        lane_q <= addr_in[1:0];
                        if (acc_error) begin
                            state_q <= StDone;
                            bus_err <= 1'b1;
                        end else begin
                            state_q    <= StAccess;
                            wait_cnt_q <= '0;
                            bus_req    <= 1'b1;
                            bus_we     <= mem_w;
                            bus_addr   <= {addr_in[31:2], 2'b00};
                            bus_be     <= req_be;
                            bus_wdata  <= req_wdata;
                        end
                    end
                end
                StAccess: begin
                    // A ready arriving on the timeout cycle still completes normally.
                    if (bus_ready) begin
                        state_q <= StDone;
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            rdata_out <= load_data;
                        end
                    end else if (wait_cnt_q == CntMax) begin
                        state_q <= StDone;
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (!bus_we) begin
                            rdata_out <= 32'h0000_0000;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_bridge.sv
// Self-checking bench for dm_bridge: directed cases plus randomized accesses checked
// against an arithmetic reference model of the load/store rules.

module tb_dm_bridge;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        mem_w;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [2:0]  dm_ctrl;
    logic [31:0] rdata_out;
    logic        cpu_stall;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_rdata = 32'h0;

    dm_bridge #(
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .mem_w    (mem_w),
        .addr_in  (addr_in),
        .wdata_in (wdata_in),
        .dm_ctrl  (dm_ctrl),
        .rdata_out(rdata_out),
        .cpu_stall(cpu_stall),
        .bus_err  (bus_err),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_be   (bus_be),
        .bus_rdata(bus_rdata),
        .bus_ready(bus_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, 0 for an undefined type.
    function automatic int unsigned acc_size(input logic [2:0] c);
        case (c)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic bit acc_ok(input logic we, input logic [2:0] c, input logic [31:0] a);
        int unsigned sz;
        sz = acc_size(c);
        if (sz == 0) return 1'b0;
        if (we && (c == 3'd2 || c == 3'd4)) return 1'b0;
        return (a % sz) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] c, input logic [31:0] a);
        int unsigned m;
        m = ((1 << acc_size(c)) - 1) << (a % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] c, input logic [31:0] w);
        int unsigned sz;
        logic [63:0] mask;
        logic [63:0] r;
        sz   = acc_size(c);
        mask = (64'd1 << (8 * sz)) - 1;
        r    = 64'd0;
        for (int i = 0; i < 4 / sz; i++) r = r | (({32'd0, w} & mask) << (8 * sz * i));
        return r[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] c, input logic [31:0] a,
                                               input logic [31:0] rd);
        int unsigned sz;
        logic [63:0] mask;
        logic [63:0] v;
        sz   = acc_size(c);
        mask = (64'd1 << (8 * sz)) - 1;
        v    = ({32'd0, rd} >> (8 * (a % 4))) & mask;
        if ((c == 3'd1 || c == 3'd3) && v[8 * sz - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // One CPU access; the bus raises ready after 'waits' ACCESS cycles.
    task automatic run_access(input string tag, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [2:0] c,
                              input logic [31:0] rd, input int waits);
        int  stalls;
        int  reqs;
        bit  done;
        bit  ok;
        bit  tmo;
        ok       = acc_ok(we, c, a);
        tmo      = ok && (waits > int'(TO));
        cpu_req  = 1'b1;
        mem_w    = we;
        addr_in  = a;
        wdata_in = wd;
        dm_ctrl  = c;
        bus_rdata = rd;
        stalls   = 0;
        reqs     = 0;
        done     = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            bus_ready = bus_req && (reqs == waits);
            #1;
            if (cpu_stall) stalls++;
            if (bus_req) begin
                reqs++;
                chk({tag, ".addr"}, bus_addr, a & 32'hFFFF_FFFC);
                chk({tag, ".be"}, {28'd0, bus_be}, {28'd0, model_be(c, a)});
                chk({tag, ".we"}, {31'd0, bus_we}, {31'd0, we});
                if (we) chk({tag, ".wdata"}, bus_wdata, model_wdata(c, wd));
            end
            if (!cpu_stall) begin
                done = 1'b1;
                if (ok && !we) exp_rdata = tmo ? 32'h0 : model_load(c, a, rd);
                chk({tag, ".err"}, {31'd0, bus_err}, {31'd0, (!ok || tmo)});
                chk({tag, ".rdata"}, rdata_out, exp_rdata);
                chk({tag, ".done_req"}, {31'd0, bus_req}, 32'd0);
                chk({tag, ".stalls"}, stalls, !ok ? 1 : (tmo ? TO + 2 : waits + 2));
                chk({tag, ".reqs"}, reqs, !ok ? 0 : (tmo ? TO + 1 : waits + 1));
                cpu_req   = 1'b0;
                bus_ready = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chk({tag, ".complete"}, {31'd0, done}, 32'd1);
        chk({tag, ".err_clear"}, {31'd0, bus_err}, 32'd0);
        chk({tag, ".idle_stall"}, {31'd0, cpu_stall}, 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        cpu_req   = 1'b0;
        mem_w     = 1'b0;
        addr_in   = 32'h0;
        wdata_in  = 32'h0;
        dm_ctrl   = 3'd0;
        bus_rdata = 32'h0;
        bus_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.rdata", rdata_out, 32'h0);
        chk("rst.req", {31'd0, bus_req}, 32'd0);
        chk("rst.be", {28'd0, bus_be}, 32'd0);
        chk("rst.err", {31'd0, bus_err}, 32'd0);
        cpu_req = 1'b1;
        #1;
        chk("rst.stall", {31'd0, cpu_stall}, 32'd0);
        cpu_req = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        run_access("word_ld", 1'b0, 32'h100, 32'h0, 3'd0, 32'hDEADBEEF, 0);
        run_access("byte_ld_s", 1'b0, 32'h103, 32'h0, 3'd3, 32'h80FF7F01, 0);
        run_access("byte_ld_u", 1'b0, 32'h103, 32'h0, 3'd4, 32'h80FF7F01, 1);
        run_access("half_st", 1'b1, 32'h102, 32'h1234ABCD, 3'd1, 32'h5555AAAA, 0);
        run_access("misal_ld", 1'b0, 32'h101, 32'h0, 3'd0, 32'h11111111, 0);
        run_access("half_ld_hi", 1'b0, 32'h206, 32'h0, 3'd1, 32'h9ABC1234, 2);
        run_access("tmo_ld", 1'b0, 32'h300, 32'h0, 3'd0, 32'hCAFEF00D, 10);
        run_access("edge_ld", 1'b0, 32'h304, 32'h0, 3'd2, 32'hFEDC8765, int'(TO));
        run_access("tmo_st", 1'b1, 32'h308, 32'hA5A5A5A5, 3'd3, 32'h0, 10);
        run_access("ill_ctrl", 1'b0, 32'h400, 32'h0, 3'd6, 32'h0, 0);
        run_access("ill_st_u", 1'b1, 32'h400, 32'h77, 3'd4, 32'h0, 0);

        // Randomized accesses.
        for (int i = 0; i < 40; i++) begin
            run_access("rnd", 1'($urandom_range(0, 1)), $urandom, $urandom,
                       3'($urandom_range(0, 5)), $urandom, int'($urandom_range(0, 5)));
        end

        // Reset asserted in the third ACCESS wait cycle.
        cpu_req   = 1'b1;
        mem_w     = 1'b0;
        addr_in   = 32'h200;
        dm_ctrl   = 3'd0;
        bus_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rst_mid.req_before", {31'd0, bus_req}, 32'd1);
        reset = 1'b0;
        #1;
        exp_rdata = 32'h0;
        chk("rst_mid.req", {31'd0, bus_req}, 32'd0);
        chk("rst_mid.stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_mid.be", {28'd0, bus_be}, 32'd0);
        chk("rst_mid.addr", bus_addr, 32'h0);
        chk("rst_mid.rdata", rdata_out, exp_rdata);
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_access("post_rst_ld", 1'b0, 32'h204, 32'h0, 3'd0, 32'h0BADCAFE, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
